// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master, four-slave bus arbiter with address decode and ack timeout
module bus_arbiter #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         m0_req_i,
  input  logic [31:0]  m0_addr_i,
  input  logic [31:0]  m0_wdata_i,
  input  logic         m0_rw_i,
  output logic [31:0]  m0_rdata_o,
  output logic         m0_done_o,
  output logic         m0_hold_o,
  input  logic         m1_req_i,
  input  logic [31:0]  m1_addr_i,
  input  logic [31:0]  m1_wdata_i,
  input  logic         m1_rw_i,
  output logic [31:0]  m1_rdata_o,
  output logic         m1_done_o,
  output logic         m1_hold_o,
  output logic [3:0]   s_sel_o,
  output logic [31:0]  s_addr_o,
  output logic [31:0]  s_wdata_o,
  output logic         s_rw_o,
  input  logic [127:0] s_rdata_i,
  input  logic [3:0]   s_ack_i,
  output logic         err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        gnt, last_m1, rw_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q, req_addr;
  logic [7:0]  cnt;
  logic [1:0]  slv;
  logic        any_req, pick_m1, dec_err, ack, to_hit, busy, resp;

  // Round-robin only matters on a tie; a lone requester always wins.
  assign any_req  = m0_req_i | m1_req_i;
  assign pick_m1  = m1_req_i & (~m0_req_i | ~last_m1);
  assign req_addr = pick_m1 ? m1_addr_i : m0_addr_i;
  assign dec_err  = |req_addr[31:30];
  assign slv      = addr_q[29:28];
  assign ack      = s_ack_i[slv];
  assign to_hit   = (cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = dec_err ? RESP : BUSY;
      BUSY: if (ack || to_hit) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt     <= 1'b0;
      last_m1 <= 1'b1;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          gnt     <= pick_m1;
          addr_q  <= req_addr;
          wdata_q <= pick_m1 ? m1_wdata_i : m0_wdata_i;
          rw_q    <= pick_m1 ? m1_rw_i : m0_rw_i;
          cnt     <= '0;
          err_q   <= dec_err;
          rdata_q <= dec_err ? ERR_DATA : 32'h0;
        end
        // Ack is tested before the timeout so a boundary ack still succeeds.
        BUSY: begin
          if (ack) begin
            rdata_q <= s_rdata_i[{slv, 5'b0} +: 32];
            err_q   <= 1'b0;
          end else if (to_hit) begin
            rdata_q <= ERR_DATA;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: last_m1 <= gnt;
        default: ;
      endcase
    end
  end

  assign busy = (state == BUSY);
  assign resp = (state == RESP);

  assign s_sel_o   = busy ? (4'b0001 << slv) : 4'b0000;
  assign s_addr_o  = busy ? addr_q : 32'h0;
  assign s_wdata_o = busy ? wdata_q : 32'h0;
  assign s_rw_o    = busy & rw_q;

  assign m0_done_o  = resp & ~gnt;
  assign m1_done_o  = resp & gnt;
  assign m0_rdata_o = m0_done_o ? rdata_q : 32'h0;
  assign m1_rdata_o = m1_done_o ? rdata_q : 32'h0;
  assign m0_hold_o  = m0_req_i & ~m0_done_o;
  assign m1_hold_o  = m1_req_i & ~m1_done_o;
  assign err_o      = resp & err_q;

endmodule
